vrf_copy_engine: RTL and testbench

Command-driven vector mover that sits directly upstream of the VRF arbiter, driving its router-side read and write request ports. It accepts a copy command (source address, destination address, word count), reads each VRF word through the arbiter read port, and writes it back through the arbiter write port at the destination. Transfers are strictly sequential, one word in flight, with a single holding register.

---
 rtl/vrf_copy_pkg.sv | 25 ++
 rtl/vrf_copy_stats.sv | 51 +++++
 rtl/vrf_copy_engine.sv | 136 +++++++++++++
 tb/tb_vrf_copy_engine.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vrf_copy_pkg.sv
// Shared types and constants for the VRF copy engine.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package vrf_copy_pkg;

    // Copy engine control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Default widths for the VRF address, VRF word and command length.
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = 1024;
    localparam int DEF_LEN_WIDTH  = 11;

    // The done strobe is a single-cycle pulse; DONE is left after one cycle.
    localparam int DONE_PULSE_CYCLES = 1;

    // Width of the optional statistics counters.
    localparam int STAT_WIDTH = 32;

endpackage

// File: rtl/vrf_copy_stats.sv
// Saturating counters of completed writes and request cycles stalled on grant.
// Latency: counters update one cycle after the counted event.
// Backpressure: none; passive observer of request/grant pairs.
module vrf_copy_stats
    import vrf_copy_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_req_i,
    input  logic                  read_gnt_i,
    input  logic                  write_req_i,
    input  logic                  write_gnt_i,
    output logic [STAT_WIDTH-1:0] stat_words_o,
    output logic [STAT_WIDTH-1:0] stat_stall_o
);

    logic [STAT_WIDTH-1:0] words_q, words_d;
    logic [STAT_WIDTH-1:0] stall_q, stall_d;
    logic                  write_done;
    logic                  stalled;

    assign write_done = write_req_i && write_gnt_i;
    assign stalled    = (read_req_i && !read_gnt_i) || (write_req_i && !write_gnt_i);

    // Increment each counter on its event, holding at all-ones once saturated.
    always_comb begin
        words_d = words_q;
        stall_d = stall_q;
        if (write_done && (words_q != '1)) begin
            words_d = words_q + 1'b1;
        end
        if (stalled && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // Counter registers; cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_q <= '0;
            stall_q <= '0;
        end else begin
            words_q <= words_d;
            stall_q <= stall_d;
        end
    end

    assign stat_words_o = words_q;
    assign stat_stall_o = stall_q;

endmodule

// File: rtl/vrf_copy_engine.sv
// Sequential VRF word mover: read one word via the arbiter, write it back at the destination.
// Latency: 2 cycles per word with immediate grants; N words take 2N+2 cycles including done.
// Backpressure: each request is held with stable address/data until granted; cmd_ready only in IDLE.
// Optional build macro: VRF_COPY_STATS_EN adds stat_words/stat_stall counter outputs.
module vrf_copy_engine
    import vrf_copy_pkg::*;
#(
    parameter int VRF_ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int VRF_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH      = DEF_LEN_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [VRF_ADDR_WIDTH-1:0] cmd_src_addr,
    input  logic [VRF_ADDR_WIDTH-1:0] cmd_dst_addr,
    input  logic [LEN_WIDTH-1:0]      cmd_len,
    output logic                      busy,
    output logic                      done,
    output logic [VRF_ADDR_WIDTH-1:0] src_addr,
    output logic                      read_req,
    input  logic                      read_gnt,
    input  logic [VRF_DATA_WIDTH-1:0] data_arbiter_send,
    output logic [VRF_ADDR_WIDTH-1:0] dst_addr,
    output logic [VRF_DATA_WIDTH-1:0] data_arbiter_recv,
    output logic                      write_req,
    input  logic                      write_gnt
`ifdef VRF_COPY_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]     stat_words,
    output logic [STAT_WIDTH-1:0]     stat_stall
`endif
);

    state_e                    state_q, state_d;
    logic [VRF_ADDR_WIDTH-1:0] src_q, src_d;
    logic [VRF_ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]      cnt_q, cnt_d;
    logic [VRF_DATA_WIDTH-1:0] hold_q, hold_d;

    // Request/status outputs are flops loaded from the next state, so no grant
    // input reaches a request output combinationally.
    logic cmd_ready_q, busy_q, done_q, read_req_q, write_req_q;

    // Next-state, address, count and holding-register logic. Grants are only
    // acted on in the state that raised the matching request.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    src_d   = cmd_src_addr;
                    dst_d   = cmd_dst_addr;
                    cnt_d   = cmd_len;
                    state_d = (cmd_len == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (read_gnt) begin
                    hold_d  = data_arbiter_send;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (write_gnt) begin
                    // Addresses wrap silently at the top of the VRF.
                    src_d   = src_q + 1'b1;
                    dst_d   = dst_q + 1'b1;
                    cnt_d   = cnt_q - 1'b1;
                    state_d = (cnt_q == LEN_WIDTH'(1)) ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            read_req_q  <= 1'b0;
            write_req_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_DONE);
            read_req_q  <= (state_d == ST_READ);
            write_req_q <= (state_d == ST_WRITE);
        end
    end

    assign cmd_ready         = cmd_ready_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign read_req          = read_req_q;
    assign write_req         = write_req_q;
    assign src_addr          = src_q;
    assign dst_addr          = dst_q;
    assign data_arbiter_recv = hold_q;

`ifdef VRF_COPY_STATS_EN
    vrf_copy_stats u_stats (
        .clk          (clk),
        .rst          (rst),
        .read_req_i   (read_req_q),
        .read_gnt_i   (read_gnt),
        .write_req_i  (write_req_q),
        .write_gnt_i  (write_gnt),
        .stat_words_o (stat_words),
        .stat_stall_o (stat_stall)
    );
`endif

endmodule

// File: tb/tb_vrf_copy_engine.sv
// Directed bench for vrf_copy_engine: copies, zero length, stalls, wrap, reset, busy command.
// Latency: checks cycle-exact request and done timing against hand-computed values.
// Backpressure: bench arbiter withholds grants for programmed numbers of cycles.
module tb_vrf_copy_engine;

    localparam int AW = 10;
    localparam int DW = 1024;
    localparam int LW = 11;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_src_addr;
    logic [AW-1:0] cmd_dst_addr;
    logic [LW-1:0] cmd_len;
    logic          busy;
    logic          done;
    logic [AW-1:0] src_addr;
    logic          read_req;
    logic          read_gnt;
    logic [DW-1:0] data_arbiter_send;
    logic [AW-1:0] dst_addr;
    logic [DW-1:0] data_arbiter_recv;
    logic          write_req;
    logic          write_gnt;
`ifdef VRF_COPY_STATS_EN
    logic [31:0]   stat_words;
    logic [31:0]   stat_stall;
    logic [31:0]   words0, stall0;
`endif

    int cmp_cnt = 0;
    int mis_cnt = 0;

    vrf_copy_engine #(
        .VRF_ADDR_WIDTH (AW),
        .VRF_DATA_WIDTH (DW),
        .LEN_WIDTH      (LW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_src_addr      (cmd_src_addr),
        .cmd_dst_addr      (cmd_dst_addr),
        .cmd_len           (cmd_len),
        .busy              (busy),
        .done              (done),
        .src_addr          (src_addr),
        .read_req          (read_req),
        .read_gnt          (read_gnt),
        .data_arbiter_send (data_arbiter_send),
        .dst_addr          (dst_addr),
        .data_arbiter_recv (data_arbiter_recv),
        .write_req         (write_req),
        .write_gnt         (write_gnt)
`ifdef VRF_COPY_STATS_EN
        ,
        .stat_words        (stat_words),
        .stat_stall        (stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench VRF contents: every word is a distinct function of its address.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        logic [7:0]    idx;
        w = '0;
        for (int i = 0; i < DW / 32; i++) begin
            idx = 8'(i);
            w[i*32 +: 32] = {6'h2A, a, idx, 8'h5C};
        end
        return w;
    endfunction

    // Read data follows the presented read address, as the arbiter would.
    assign data_arbiter_send = mem_word(src_addr);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            mis_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_data(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            mis_cnt++;
            $error("FAIL %s: observed low64 %0h expected low64 %0h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and follow it to completion. rd_st/wr_st: grant delay
    // in cycles per word; exp_done: cycle after acceptance in which done is due.
    task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic [LW-1:0] len, input int rd_st, input int wr_st,
                            input int exp_done, input bit poke);
        int            rel;
        int            words;
        int            rd_wait;
        int            wr_wait;
        bit            got_done;
        logic [AW-1:0] exp_s;
        logic [AW-1:0] exp_d;
        words    = 0;
        rd_wait  = 0;
        wr_wait  = 0;
        got_done = 1'b0;
        check("idle_ready", cmd_ready, 1'b1);
        cmd_src_addr = s;
        cmd_dst_addr = d;
        cmd_len      = len;
        cmd_valid    = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("start_read_req", read_req, (len != 0));
        check("start_busy", busy, 1'b1);
        for (rel = 1; rel <= 200; rel++) begin
            exp_s = s + AW'(words);
            exp_d = d + AW'(words);
            if (poke && rel == 1) begin
                cmd_src_addr = 10'h3AA;
                cmd_dst_addr = 10'h155;
                cmd_len      = 11'd5;
                cmd_valid    = 1'b1;
                check("busy_not_ready", cmd_ready, 1'b0);
            end
            if (done && cmd_ready) check("done_ready_excl", 1'b1, 1'b0);
            if (len == 0) begin
                check("zero_no_rd", read_req, 1'b0);
                check("zero_no_wr", write_req, 1'b0);
            end
            if (read_req) begin
                check("rd_addr", src_addr, exp_s);
                if (rd_wait < rd_st) begin
                    read_gnt = 1'b0;
                    rd_wait++;
                end else begin
                    read_gnt = 1'b1;
                    rd_wait  = 0;
                end
            end
            if (write_req) begin
                check("wr_addr", dst_addr, exp_d);
                check_data("wr_data", data_arbiter_recv, mem_word(exp_s));
                if (wr_wait < wr_st) begin
                    write_gnt = 1'b0;
                    wr_wait++;
                end else begin
                    write_gnt = 1'b1;
                    wr_wait   = 0;
                    words++;
                end
            end
            if (done) begin
                got_done = 1'b1;
                check("done_cycle", rel, exp_done);
                check("done_words", words, 64'(len));
                break;
            end
            tick();
            read_gnt  = 1'b0;
            write_gnt = 1'b0;
            cmd_valid = 1'b0;
        end
        if (!got_done) check("done_timeout", 1'b0, 1'b1);
        tick();
        check("after_done_ready", cmd_ready, 1'b1);
        check("after_done_pulse", done, 1'b0);
        check("after_done_busy", busy, 1'b0);
    endtask

    initial begin
        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_src_addr = '0;
        cmd_dst_addr = '0;
        cmd_len      = '0;
        read_gnt     = 1'b0;
        write_gnt    = 1'b0;
        tick();
        tick();

        // Reset values.
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_read_req", read_req, 1'b0);
        check("rst_write_req", write_req, 1'b0);
        check("rst_src_addr", src_addr, 10'h000);
        check("rst_dst_addr", dst_addr, 10'h000);
        check_data("rst_wdata", data_arbiter_recv, {DW{1'b0}});
        rst = 1'b0;
        tick();

        // Grant while no request is up must not start anything.
        read_gnt  = 1'b1;
        write_gnt = 1'b1;
        tick();
        read_gnt  = 1'b0;
        write_gnt = 1'b0;
        check("stray_gnt_idle", busy, 1'b0);

        // Basic copy: 3 words, done 7 cycles after the accepting edge.
        run_copy(10'h010, 10'h200, 11'd3, 0, 0, 7, 1'b0);

        // Zero length: done in T+1, ready in T+2.
        run_copy(10'h123, 10'h321, 11'd0, 0, 0, 1, 1'b0);

        // Grant stalls: read held 5 cycles, write held 3 cycles.
`ifdef VRF_COPY_STATS_EN
        words0 = stat_words;
        stall0 = stat_stall;
`endif
        run_copy(10'h055, 10'h0AA, 11'd1, 5, 3, 11, 1'b0);
`ifdef VRF_COPY_STATS_EN
        check("stat_stall_delta", stat_stall - stall0, 32'd8);
        check("stat_words_delta", stat_words - words0, 32'd1);
`endif

        // Address wrap: reads 3FE, 3FF, 000, 001.
        run_copy(10'h3FE, 10'h100, 11'd4, 0, 0, 9, 1'b0);

        // Command offered while busy is ignored.
        run_copy(10'h020, 10'h300, 11'd2, 0, 0, 5, 1'b1);

        // Reset while in WRITE.
        cmd_src_addr = 10'h040;
        cmd_dst_addr = 10'h140;
        cmd_len      = 11'd2;
        cmd_valid    = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("rm_read_req", read_req, 1'b1);
        read_gnt = 1'b1;
        tick();
        read_gnt = 1'b0;
        check("rm_write_req", write_req, 1'b1);
        rst = 1'b1;
        #1;
        check("rm_write_req_async", write_req, 1'b0);
        check("rm_busy_async", busy, 1'b0);
        check("rm_ready_async", cmd_ready, 1'b1);
        check("rm_dst_async", dst_addr, 10'h000);
        tick();
        rst = 1'b0;
        tick();
        check("rm_ready_after", cmd_ready, 1'b1);
        check("rm_rdreq_after", read_req, 1'b0);

        // A fresh command after the abandoned one runs normally.
        run_copy(10'h050, 10'h150, 11'd1, 0, 0, 3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

endmodule
